sseg4_scan_ctrl: RTL and testbench



---
 rtl/sseg4_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sseg4_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg4_scan_ctrl.sv
// Four-digit seven-segment scan controller: sequential binary-to-BCD conversion
// (or raw hex capture) into a display register, then time-multiplexed onto the
// shared segment decoder with active-low anodes and leading-zero blanking.

module sseg_decoder (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    always_comb begin
        o_seg = 7'b1111111;
        unique case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

module sseg4_scan_ctrl #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] bin,
    input  logic        load,
    input  logic        hex_mode,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(DIV - 1);

    typedef enum logic {StIdle, StConv} state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_bcd, w_bcd_next, w_bcd_adj;
    logic [10:0] r_sh, w_sh_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [15:0] r_disp, w_disp_next;
    logic        r_mode, w_mode_next;
    logic [CW-1:0] r_ref;
    logic [1:0]  r_idx;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_unused;

    // Double-dabble add-3 correction on every BCD nibble
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next-state and datapath
    always_comb begin
        w_state_next = r_state;
        w_bcd_next   = r_bcd;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        w_disp_next  = r_disp;
        w_mode_next  = r_mode;
        unique case (r_state)
            StIdle: begin
                if (load) begin
                    if (hex_mode) begin
                        w_disp_next = {5'b0, bin};
                        w_mode_next = 1'b1;
                    end else begin
                        w_sh_next    = bin;
                        w_bcd_next   = 16'h0000;
                        w_cnt_next   = 4'd11;
                        w_mode_next  = 1'b0;
                        w_state_next = StConv;
                    end
                end
            end
            StConv: begin
                w_bcd_next = {w_bcd_adj[14:0], r_sh[10]};
                w_sh_next  = {r_sh[9:0], 1'b0};
                w_cnt_next = r_cnt - 4'd1;
                // Last shift: publish the whole result at once
                if (r_cnt == 4'd1) begin
                    w_disp_next  = {w_bcd_adj[14:0], r_sh[10]};
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Conversion state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_bcd   <= 16'h0000;
            r_sh    <= 11'h000;
            r_cnt   <= 4'd0;
            r_disp  <= 16'h0000;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bcd   <= w_bcd_next;
            r_sh    <= w_sh_next;
            r_cnt   <= w_cnt_next;
            r_disp  <= w_disp_next;
            r_mode  <= w_mode_next;
        end
    end

    // Refresh counter and digit index; never stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_idx <= 2'd0;
        end else if (r_ref == REF_LAST) begin
            r_ref <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    // Leading-zero blanking for the selected digit
    always_comb begin
        w_blank = 1'b0;
        unique case (r_idx)
            2'd0: w_blank = 1'b0;
            2'd1: w_blank = (r_disp[15:4] == 12'h000);
            2'd2: w_blank = (r_disp[15:8] == 8'h00);
            2'd3: w_blank = (r_disp[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];
    assign an       = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    assign busy     = (r_state == StConv);
    assign dp       = 1'b1;
    // Latched mode has no effect on the display path
    assign w_unused = r_mode;

    sseg_decoder u_dec (
        .i_hex (w_nib),
        .o_seg (seg)
    );

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Bench for sseg4_scan_ctrl: table of load vectors, hand-written corner
// sequences, and random traffic against a latency/arithmetic reference model.

module tb_sseg4_scan_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] bin = '0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        busy, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    sseg4_scan_ctrl #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin      (bin),
        .load     (load),
        .hex_mode (hex_mode),
        .busy     (busy),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: shown value, pending result, cycles left, edges since reset
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    int          m_busy = 0;
    int          m_cyc  = 0;

    typedef struct {
        logic [10:0] v_bin;
        logic        v_hex;
        logic [15:0] v_disp;
        int          v_busy;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Expected anode/segment pattern for a display value after cyc edges since reset
    task automatic exp_out(input logic [15:0] d, input int cyc,
                           output logic [3:0] e_an, output logic [6:0] e_seg);
        int idx;
        idx   = (cyc / DIV) % 4;
        e_seg = seg_of(d[4*idx +: 4]);
        if (idx != 0 && (d >> (4 * idx)) == 16'h0) e_an = 4'b1111;
        else e_an = ~(4'b0001 << idx);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_disp = '0;
            m_busy = 0;
            m_cyc  = 0;
        end else begin
            m_cyc++;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (load) begin
                if (hex_mode) begin
                    m_disp = 16'(bin);
                end else begin
                    m_pend = to_bcd(int'(bin));
                    m_busy = 11;
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        @(posedge clk);
        model_edge();
        #1;
        exp_out(m_disp, m_cyc, e_an, e_seg);
        check("busy", 32'(busy), 32'(m_busy > 0));
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'd1);
    endtask

    // One full frame compared against a fixed expected display value
    task automatic frame_check(input string name, input logic [15:0] d);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        for (int k = 0; k < 4 * DIV; k++) begin
            step();
            exp_out(d, m_cyc, e_an, e_seg);
            check({name, "_an"}, 32'(an), 32'(e_an));
            check({name, "_seg"}, 32'(seg), 32'(e_seg));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nb;
        vecs[0] = '{11'd2047,  1'b0, 16'h2047, 11};
        vecs[1] = '{11'd5,     1'b0, 16'h0005, 11};
        vecs[2] = '{11'h7A3,   1'b1, 16'h07A3, 0};
        vecs[3] = '{11'd1000,  1'b0, 16'h1000, 11};
        vecs[4] = '{11'd0,     1'b0, 16'h0000, 11};
        vecs[5] = '{11'd999,   1'b0, 16'h0999, 11};
        vecs[6] = '{11'h00F,   1'b1, 16'h000F, 0};
        vecs[7] = '{11'd1209,  1'b0, 16'h1209, 11};

        // Reset state and blanked scan
        do_reset();
        check("rst_an", 32'(an), 32'(4'b1110));
        check("rst_seg", 32'(seg), 32'(7'b1000000));
        check("rst_busy", 32'(busy), 32'd0);
        frame_check("blank", 16'h0000);

        // Table-driven loads: busy length and full-frame display
        for (int i = 0; i < 8; i++) begin
            bin = vecs[i].v_bin; hex_mode = vecs[i].v_hex; load = 1'b1;
            step();
            load = 1'b0;
            nb = busy ? 1 : 0;
            for (int k = 0; k < 20 && busy; k++) begin
                step();
                if (busy) nb++;
            end
            check("busy_len", 32'(nb), 32'(vecs[i].v_busy));
            frame_check("vec", vecs[i].v_disp);
        end

        // Second load at E5 is ignored, result appears at E11
        bin = 11'd1000; hex_mode = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            if (e == 5) begin bin = 11'd9; load = 1'b1; end
            else load = 1'b0;
            step();
            if (e == 10) check("busy_e10", 32'(busy), 32'd1);
        end
        load = 1'b0;
        check("busy_e11", 32'(busy), 32'd0);
        frame_check("ignored_load", 16'h1000);

        // Hex load during conversion is ignored too
        bin = 11'd321; hex_mode = 1'b0; load = 1'b1;
        step();
        bin = 11'h7FF; hex_mode = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 20 && busy; k++) step();
        frame_check("hex_ignored", 16'h0321);

        // Reset at E6 aborts the conversion
        bin = 11'd1000; hex_mode = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_an", 32'(an), 32'(4'b1110));
        check("abort_seg", 32'(seg), 32'(7'b1000000));
        frame_check("abort", 16'h0000);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bin      = 11'($urandom_range(0, 2047));
            hex_mode = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
